// File: rtl/ch0re_pl_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ch0re_pl_ctrl
//  Purpose  : Central pipeline sequencer for the 5-stage ch0re core
//             (IF/ID/EX/MEM/WB). Turns decoder hazard/illegal flags, EX
//             branch resolution and the LSU busy flag into per-stage load
//             enables, bubble/flush strobes and the PC source select. Runs
//             the drain-then-trap sequence for illegal instructions.
//             Owns no datapath.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   clk           in   core clock
//   rst           in   synchronous, active-high reset
//   i_id_valid    in   ID holds a real (non-bubble) instruction
//   i_id_illegal  in   decoder: illegal instruction in ID
//   i_id_stall    in   decoder: load-use hazard in ID
//   i_br_taken    in   EX: branch/jump resolved taken this cycle
//   i_mem_busy    in   LSU: access not complete, freeze pipeline
//   o_if_en       out  PC / IF-ID register load enable
//   o_id_en       out  ID-EX register load enable
//   o_ex_en       out  EX-MEM register load enable
//   o_mem_en      out  MEM-WB register load enable
//   o_id_flush    out  load bubble into IF-ID
//   o_ex_flush    out  load bubble into ID-EX
//   o_pc_sel      out  0=PC+4, 1=branch target, 2=trap vector
//   o_trap        out  one-cycle illegal-instruction trap strobe
//   o_stall_cnt   out  saturating count of cycles with o_if_en==0
// ============================================================================
module ch0re_pl_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_id_valid,
  input  logic             i_id_illegal,
  input  logic             i_id_stall,
  input  logic             i_br_taken,
  input  logic             i_mem_busy,
  output logic             o_if_en,
  output logic             o_id_en,
  output logic             o_ex_en,
  output logic             o_mem_en,
  output logic             o_id_flush,
  output logic             o_ex_flush,
  output logic [1:0]       o_pc_sel,
  output logic             o_trap,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] C_DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] C_PC_SEQ  = 2'd0;
  localparam logic [1:0] C_PC_BR   = 2'd1;
  localparam logic [1:0] C_PC_TRAP = 2'd2;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_TRAP     = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [DW-1:0] r_drain_cnt;
  logic [DW-1:0] w_drain_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  always_comb begin
    o_if_en         = 1'b1;
    o_id_en         = 1'b1;
    o_ex_en         = 1'b1;
    o_mem_en        = 1'b1;
    o_id_flush      = 1'b0;
    o_ex_flush      = 1'b0;
    o_pc_sel        = C_PC_SEQ;
    o_trap          = 1'b0;
    w_next_state    = r_state;
    w_drain_cnt_nxt = r_drain_cnt;

    if (rst) begin
      o_if_en    = 1'b0;
      o_id_en    = 1'b0;
      o_ex_en    = 1'b0;
      o_mem_en   = 1'b0;
      o_id_flush = 1'b1;
      o_ex_flush = 1'b1;
    end else begin
      case (r_state)
        // MEM_WAIT shares the RUN rules: while busy the freeze rule keeps
        // it parked, and on the first non-busy cycle the remaining rules
        // (including a branch held in EX) apply in that same cycle.
        S_RUN, S_MEM_WAIT: begin
          if (i_mem_busy) begin
            o_if_en      = 1'b0;
            o_id_en      = 1'b0;
            o_ex_en      = 1'b0;
            o_mem_en     = 1'b0;
            w_next_state = S_MEM_WAIT;
          end else if (i_br_taken) begin
            // Illegal/stall flags in ID belong to the wrong path here.
            o_pc_sel     = C_PC_BR;
            o_id_flush   = 1'b1;
            o_ex_flush   = 1'b1;
            w_next_state = S_RUN;
          end else if (i_id_valid && i_id_illegal) begin
            o_if_en         = 1'b0;
            o_ex_flush      = 1'b1;
            w_drain_cnt_nxt = '0;
            w_next_state    = S_DRAIN;
          end else if (i_id_stall) begin
            o_if_en      = 1'b0;
            o_id_en      = 1'b0;
            o_ex_flush   = 1'b1;
            w_next_state = S_RUN;
          end else begin
            w_next_state = S_RUN;
          end
        end

        S_DRAIN: begin
          o_if_en    = 1'b0;
          o_ex_flush = 1'b1;
          if (i_mem_busy) begin
            // Frozen: older instructions cannot retire, so no progress.
            o_ex_en  = 1'b0;
            o_mem_en = 1'b0;
          end else if (i_br_taken) begin
            // An older branch redirects; the illegal instr is on a dead path.
            o_if_en      = 1'b1;
            o_pc_sel     = C_PC_BR;
            o_id_flush   = 1'b1;
            w_next_state = S_RUN;
          end else if (r_drain_cnt == C_DRAIN_LAST) begin
            w_next_state = S_TRAP;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt + DW'(1);
          end
        end

        S_TRAP: begin
          o_if_en      = 1'b0;
          o_pc_sel     = C_PC_TRAP;
          o_trap       = 1'b1;
          o_id_flush   = 1'b1;
          o_ex_flush   = 1'b1;
          w_next_state = S_RUN;
        end

        default: begin
          w_next_state = S_RUN;
        end
      endcase
    end
  end

  // Performance counter: saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stall_cnt <= '0;
    end else if (!o_if_en && (o_stall_cnt != {CNT_W{1'b1}})) begin
      o_stall_cnt <= o_stall_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ch0re_pl_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ch0re_pl_ctrl
//  Purpose  : Scoreboard bench for ch0re_pl_ctrl. Stimulus drives inputs on
//             the falling edge and pushes the reference model's expected
//             outputs; a monitor samples the DUT mid-cycle and compares.
//             A second instance with a 3-bit counter exercises saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ch0re_pl_ctrl;

  localparam int DRAIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic id_valid = 1'b0, id_illegal = 1'b0, id_stall = 1'b0;
  logic br_taken = 1'b0, mem_busy = 1'b0;

  logic        if_en, id_en, ex_en, mem_en, id_flush, ex_flush, trap;
  logic [1:0]  pc_sel;
  logic [31:0] stall_cnt;
  logic        s_if_en, s_id_en, s_ex_en, s_mem_en, s_id_flush, s_ex_flush, s_trap;
  logic [1:0]  s_pc_sel;
  logic [2:0]  s_stall_cnt;

  ch0re_pl_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_id_valid(id_valid), .i_id_illegal(id_illegal), .i_id_stall(id_stall),
    .i_br_taken(br_taken), .i_mem_busy(mem_busy),
    .o_if_en(if_en), .o_id_en(id_en), .o_ex_en(ex_en), .o_mem_en(mem_en),
    .o_id_flush(id_flush), .o_ex_flush(ex_flush), .o_pc_sel(pc_sel),
    .o_trap(trap), .o_stall_cnt(stall_cnt)
  );

  ch0re_pl_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst),
    .i_id_valid(id_valid), .i_id_illegal(id_illegal), .i_id_stall(id_stall),
    .i_br_taken(br_taken), .i_mem_busy(mem_busy),
    .o_if_en(s_if_en), .o_id_en(s_id_en), .o_ex_en(s_ex_en), .o_mem_en(s_mem_en),
    .o_id_flush(s_id_flush), .o_ex_flush(s_ex_flush), .o_pc_sel(s_pc_sel),
    .o_trap(s_trap), .o_stall_cnt(s_stall_cnt)
  );

  typedef struct packed {
    logic       if_en, id_en, ex_en, mem_en, id_fl, ex_fl;
    logic [1:0] pc;
    logic       trap;
  } outs_t;

  typedef struct {
    outs_t   o;
    longint  cnt;
  } exp_t;

  exp_t q[$];
  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: "mode" 0=running, 1=frozen by LSU, 2=draining with
  // drain_left cycles of retirement still owed, 3=trap cycle.
  int     mode       = 0;
  int     drain_left = 0;
  longint stalls     = 0;

  function automatic outs_t all_on();
    outs_t o;
    o.if_en = 1; o.id_en = 1; o.ex_en = 1; o.mem_en = 1;
    o.id_fl = 0; o.ex_fl = 0; o.pc = 2'd0; o.trap = 0;
    return o;
  endfunction

  function automatic outs_t branch_action();
    outs_t o;
    o = all_on();
    o.pc = 2'd1; o.id_fl = 1; o.ex_fl = 1;
    return o;
  endfunction

  task automatic model_cycle(output outs_t o);
    o = all_on();
    if (rst) begin
      o.if_en = 0; o.id_en = 0; o.ex_en = 0; o.mem_en = 0;
      o.id_fl = 1; o.ex_fl = 1;
      mode = 0;
      stalls = 0;
      return;
    end
    if (mode == 3) begin
      o.if_en = 0; o.pc = 2'd2; o.trap = 1; o.id_fl = 1; o.ex_fl = 1;
      mode = 0;
    end else if (mode == 2) begin
      if (mem_busy) begin
        o.if_en = 0; o.ex_fl = 1; o.ex_en = 0; o.mem_en = 0;
      end else if (br_taken) begin
        o = branch_action();
        mode = 0;
      end else begin
        o.if_en = 0; o.ex_fl = 1;
        drain_left--;
        if (drain_left == 0) mode = 3;
      end
    end else begin
      if (mem_busy) begin
        o.if_en = 0; o.id_en = 0; o.ex_en = 0; o.mem_en = 0;
        mode = 1;
      end else if (br_taken) begin
        o = branch_action();
        mode = 0;
      end else if (id_valid && id_illegal) begin
        o.if_en = 0; o.ex_fl = 1;
        mode = 2;
        drain_left = DRAIN;
      end else if (id_stall) begin
        o.if_en = 0; o.id_en = 0; o.ex_fl = 1;
        mode = 0;
      end else begin
        mode = 0;
      end
    end
    if (!o.if_en && stalls < 64'hFFFF_FFFF) stalls++;
  endtask

  task automatic apply(input logic r, input logic v, input logic il,
                       input logic st, input logic br, input logic bz);
    exp_t e;
    @(negedge clk);
    rst = r; id_valid = v; id_illegal = il; id_stall = st;
    br_taken = br; mem_busy = bz;
    #1;
    e.cnt = stalls;
    model_cycle(e.o);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle, so each mid-cycle sample
  // consumes one expected entry.
  initial begin : monitor
    exp_t  e;
    outs_t got;
    longint sat_exp;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        got.if_en = if_en; got.id_en = id_en; got.ex_en = ex_en; got.mem_en = mem_en;
        got.id_fl = id_flush; got.ex_fl = ex_flush; got.pc = pc_sel; got.trap = trap;
        n_vec++;
        if (got !== e.o) begin
          n_miss++;
          $display("FAIL outputs t=%0t got if/id/ex/mem/idf/exf/pc/trap=%b required=%b",
                   $time, got, e.o);
        end
        n_vec++;
        if (stall_cnt !== e.cnt[31:0]) begin
          n_miss++;
          $display("FAIL stall_cnt t=%0t got=%0d required=%0d", $time, stall_cnt, e.cnt);
        end
        sat_exp = (e.cnt > 7) ? 64'd7 : e.cnt;
        n_vec++;
        if (s_stall_cnt !== sat_exp[2:0]) begin
          n_miss++;
          $display("FAIL stall_cnt_sat t=%0t got=%0d required=%0d", $time, s_stall_cnt, sat_exp);
        end
        n_vec++;
        if (trap === 1'b1 && pc_sel === 2'd1) begin
          n_miss++;
          $display("FAIL trap_vs_branch t=%0t got trap=1 pc_sel=1 required not both", $time);
        end
      end
    end
  end

  initial begin : stimulus
    int r;
    // Bring both instances out of an unknown state before checking.
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset held, then idle.
    apply(1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    idle(3);
    // Single load-use stall.
    apply(0, 1, 0, 1, 0, 0);
    idle(2);
    // Branch beats an illegal instruction in ID.
    apply(0, 1, 1, 0, 1, 0);
    idle(2);
    // Illegal -> drain -> trap.
    apply(0, 1, 1, 0, 0, 0);
    idle(6);
    // Illegal, LSU busy 5 cycles during drain.
    apply(0, 1, 1, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 5; i++) apply(0, 0, 0, 0, 0, 1);
    idle(5);
    // Illegal, then an older branch aborts the drain.
    apply(0, 1, 1, 0, 0, 0);
    idle(1);
    apply(0, 0, 0, 0, 1, 0);
    idle(4);
    // Illegal, reset in the second drain cycle.
    apply(0, 1, 1, 0, 0, 0);
    idle(1);
    apply(1, 0, 0, 0, 0, 0);
    idle(5);
    // Memory freeze in RUN with a branch waiting behind it.
    apply(0, 0, 0, 0, 1, 1);
    apply(0, 0, 0, 0, 1, 1);
    apply(0, 0, 0, 0, 1, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic rr, v, il, st, br, bz;
      r  = $urandom_range(0, 99);
      rr = (r < 2);
      v  = ($urandom_range(0, 99) < 80);
      il = ($urandom_range(0, 99) < 10);
      st = ($urandom_range(0, 99) < 15);
      br = ($urandom_range(0, 99) < 12);
      bz = ($urandom_range(0, 99) < 15);
      apply(rr, v, il, st, br, bz);
    end
    idle(4);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_miss++;
      $display("FAIL drain_queue got=%0d pending required=0", q.size());
    end
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
